multicycle_control_sequencer: RTL

Multi-cycle control unit and PC sequencer for the 24-bit CPU datapath. It owns the program counter and the instruction register, and fetches from instruction memory over a req/ack handshake. It decodes the 4-bit opcode and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. In each state it drives the datapath controls: RegDst, ALUsrc, MemToReg, Regwrite, MemRead, MemWrite, ALUop and Branch.

---
 rtl/multicycle_control_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_sequencer.sv
// Multi-cycle control unit and PC sequencer for the 24-bit CPU datapath.
// Owns pc and the instruction register, fetches over imem_req/imem_ack,
// and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// All datapath controls are registered: they are computed from the next
// state and next instruction, so they change only on clock edges.
// Optional feature macro: CTRL_PERF_CNT_EN (retired-instruction counter).
module multicycle_control_sequencer #(
  parameter logic [23:0] RESET_PC      = 24'h000000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [23:0] imem_addr,
  input  logic        imem_ack,
  input  logic [23:0] instr_in,
  input  logic        alu_zero,
  input  logic [23:0] branch_target,
  output logic [23:0] pc,
  output logic [23:0] instr,
  output logic        RegDst,
  output logic        ALUsrc,
  output logic        MemToReg,
  output logic        Regwrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUop,
  output logic        halted,
  output logic        trap,
  output logic [23:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  localparam logic [3:0]  OP_R    = 4'h0;
  localparam logic [3:0]  OP_ADDI = 4'h1;
  localparam logic [3:0]  OP_LW   = 4'h2;
  localparam logic [3:0]  OP_SW   = 4'h3;
  localparam logic [3:0]  OP_BEQ  = 4'h4;
  localparam logic [3:0]  OP_HALT = 4'hF;
  localparam logic [15:0] WD_LIMIT = 16'(FETCH_TIMEOUT);

  state_t      state_q, state_d;
  logic [23:0] pc_q, pc_d, instr_q, instr_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        imem_req_q, imem_req_d;
  logic        regdst_q, regdst_d, alusrc_q, alusrc_d, memtoreg_q, memtoreg_d;
  logic        regwrite_q, regwrite_d, memread_q, memread_d;
  logic        memwrite_q, memwrite_d, branch_q, branch_d;
  logic [1:0]  aluop_q, aluop_d;
  logic        halted_q, halted_d, trap_q, trap_d;
  logic [3:0]  op_q, op_d;

  assign op_q = instr_q[23:20];
  assign op_d = instr_d[23:20];

  // State register: every flop clears asynchronously, aborting any instruction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      wd_cnt_q   <= '0;
      imem_req_q <= 1'b0;
      regdst_q   <= 1'b0;
      alusrc_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      aluop_q    <= 2'b00;
      halted_q   <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      wd_cnt_q   <= wd_cnt_d;
      imem_req_q <= imem_req_d;
      regdst_q   <= regdst_d;
      alusrc_q   <= alusrc_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      branch_q   <= branch_d;
      aluop_q    <= aluop_d;
      halted_q   <= halted_d;
      trap_q     <= trap_d;
    end
  end

  // Next state, pc, instruction register and fetch watchdog.
  // imem_req is registered and low out of reset, so the first FETCH cycle
  // after release issues no request; ack is only honoured while requesting.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    wd_cnt_d = '0;
    case (state_q)
      S_FETCH: begin
        wd_cnt_d = wd_cnt_q;
        if (imem_req_q) begin
          if (imem_ack) begin
            instr_d  = instr_in;
            pc_d     = pc_q + 24'd3;
            state_d  = S_DECODE;
            wd_cnt_d = '0;
          end else if (WD_LIMIT != 16'd0 && wd_cnt_q + 16'd1 == WD_LIMIT) begin
            state_d = S_TRAP;
          end else begin
            wd_cnt_d = wd_cnt_q + 16'd1;
          end
        end
      end
      S_DECODE: begin
        case (op_q)
          OP_HALT:                               state_d = S_HALT;
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ:   state_d = S_EXEC;
          default:                               state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_BEQ: begin
            if (alu_zero) pc_d = branch_target;
            state_d = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM:   state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
      S_WB:    state_d = S_FETCH;
      default: state_d = state_q;
    endcase
  end

  // Registered controls, derived from where the machine is going next.
  always_comb begin
    logic live;
    live       = (state_d inside {S_DECODE, S_EXEC, S_MEM, S_WB});
    imem_req_d = (state_d == S_FETCH);
    halted_d   = (state_d == S_HALT);
    trap_d     = (state_d == S_TRAP);
    regdst_d   = 1'b0;
    alusrc_d   = 1'b0;
    memtoreg_d = 1'b0;
    aluop_d    = 2'b00;
    if (live) begin
      case (op_d)
        OP_R:    begin regdst_d = 1'b1; aluop_d = 2'b10; end
        OP_ADDI: alusrc_d = 1'b1;
        OP_LW:   begin alusrc_d = 1'b1; memtoreg_d = 1'b1; end
        OP_SW:   alusrc_d = 1'b1;
        OP_BEQ:  aluop_d = 2'b01;
        default: ;
      endcase
    end
    branch_d   = (state_d == S_EXEC) && (op_d == OP_BEQ);
    memwrite_d = (state_d == S_MEM) && (op_d == OP_SW);
    memread_d  = (state_d inside {S_MEM, S_WB}) && (op_d == OP_LW);
    regwrite_d = (state_d == S_WB);
  end

`ifdef CTRL_PERF_CNT_EN
  logic [23:0] instret_q, instret_d;
  logic        retire;

  // Retire = return to FETCH from an execution state; saturating count.
  always_comb begin
    retire    = (state_d == S_FETCH) && (state_q inside {S_EXEC, S_MEM, S_WB});
    instret_d = instret_q;
    if (retire && instret_q != 24'hFFFFFF) instret_d = instret_q + 24'd1;
  end

  // Retired-instruction counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) instret_q <= '0;
    else          instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = 24'h000000;
`endif

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign RegDst    = regdst_q;
  assign ALUsrc    = alusrc_q;
  assign MemToReg  = memtoreg_q;
  assign Regwrite  = regwrite_q;
  assign MemRead   = memread_q;
  assign MemWrite  = memwrite_q;
  assign Branch    = branch_q;
  assign ALUop     = aluop_q;
  assign halted    = halted_q;
  assign trap      = trap_q;

endmodule
